pipe_scroller: RTL and testbench
================================

Name: pipe_scroller

Overview:
- Producer of the 32-bit packed pipe register consumed by the pipe renderer.
- Spawns one pipe at the right screen edge with a pseudo-random gap centre, scrolls it left once per frame, and clears the register to all-zero ("no pipe") once it leaves the left edge.
- Emits a one-cycle pass pulse when the pipe's right edge crosses the bird column, for the score counter.
- One instance per pipe slot; instances differ by SEED and SPAWN_DELAY.

Parameters:
- SCREEN_WIDTH, 640, spawn x position (left edge at spawn)
- PIPE_WIDTH, 70, pipe width in pixels; right edge = left edge + PIPE_WIDTH
- GAP_HEIGHT, 120, gap height written to every spawned pipe (must be nonzero)
- GAP_MIN_CENTER, 100, smallest gap centre; centre = GAP_MIN_CENTER + lfsr[7:0] (100..355)
- SPEED, 2, pixels moved left per frame
- SPAWN_DELAY, 40, frames between start/despawn and the next spawn
- BIRD_X, 200, bird column used for pass detection
- SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vblank)
- run  in  1  game running; low freezes all state
- start  in  1  one-cycle pulse to begin a new game
- pipe_reg  out  32  packed pipe: [31:28]=0, [27:18] left edge, [17:9] gap centre, [8:0] gap height; all-zero means no pipe
- pass_pulse  out  1  one-cycle pulse when the pipe passes BIRD_X
- pipe_active  out  1  high while in SCROLL

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, pipe_reg=0, pass_pulse=0, pipe_active=0, frame counter=0, LFSR=SEED.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk regardless of run/state so spawn values depend on player timing. Never 0.
- Priority per cycle: resetn > start > run/frame_tick.
- start (any state): pipe_reg←0, counter←SPAWN_DELAY, state←DELAY. The start takes effect even when run is low.
- IDLE: pipe_reg=0. Leaves only on start.
- DELAY: on frame_tick && run, decrement counter. If counter==1 at that tick, spawn in the same cycle:
  - left=SCREEN_WIDTH, centre=GAP_MIN_CENTER+lfsr[7:0], height=GAP_HEIGHT.
  - state←SCROLL.
  - SPAWN_DELAY=0 is treated as 1.
- SCROLL: on frame_tick && run:
  - if left < SPEED: pipe_reg←0, counter←SPAWN_DELAY, state←DELAY.
  - else left←left−SPEED; centre and height are held.
- Pass detection in SCROLL on an update tick: pass_pulse=1 for exactly the next cycle iff old_left+PIPE_WIDTH ≥ BIRD_X and new_left+PIPE_WIDTH < BIRD_X. The despawn tick never pulses. Right-edge arithmetic is 11 bits, no wrap.
- Latency: pipe_reg, pass_pulse and pipe_active are registered and change one clk after the qualifying frame_tick/start edge. No combinational input→output paths.
- run=0: counter, pipe_reg and state are held. frame_tick is ignored. pass_pulse=0.
- frame_tick held high for several cycles: each high cycle counts as a tick. The source guarantees single-cycle pulses.
- Invariant: a spawned pipe_reg is never all-zero (height≥1).

Optional Feature:
- PIPE_SPEEDUP_EN defined:
  - Internal speed register starts at SPEED on reset/start.
  - Speed increments by 1 after every 8th pass_pulse, saturating at 2*SPEED.
  - Despawn compare and decrement use the current speed.
- PIPE_SPEEDUP_EN undefined: speed is the constant SPEED and no pass counter is synthesised.

Test Plan:
- Reset with run=1 and ticks active → pipe_reg=0, pass_pulse=0, pipe_active=0 for 100 frames (IDLE without start).
- start, run=1, 40 frame_ticks → one clk after 40th tick: pipe_reg[27:18]=640, [8:0]=120, [17:9] in 100..355, [31:28]=0, pipe_active=1.
- Continue ticks → after k frames left=640−2k. Tick 256 (left 130→128, right 200→198) → pass_pulse high exactly one cycle; no other pulse.
- Tick 320 gives left=0; tick 321 → pipe_reg=0, pipe_active=0. New spawn after 40 more ticks with left=640.
- run=0 mid-SCROLL (left=400) for 50 ticks → pipe_reg unchanged. run=1 → next tick left=398. start mid-SCROLL → pipe_reg=0 next cycle and DELAY restarts.
- PIPE_SPEEDUP_EN: after 8 passes, per-frame step=3. After 16 passes, step=4 and stays 4.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller: spawns one pipe at the right screen edge and scrolls it
// left once per frame. The pipe is cleared once it leaves the left edge.
// A one-cycle pass pulse fires when the right edge crosses the bird column.
// Optional build macro: PIPE_SPEEDUP_EN. When it is defined, the scroll
// speed grows by 1 after every 8th pass, up to 2*SPEED.
module pipe_scroller #(
  parameter int          SCREEN_WIDTH   = 640,
  parameter int          PIPE_WIDTH     = 70,
  parameter int          GAP_HEIGHT     = 120,
  parameter int          GAP_MIN_CENTER = 100,
  parameter int          SPEED          = 2,
  parameter int          SPAWN_DELAY    = 40,
  parameter int          BIRD_X         = 200,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        start,
  output logic [31:0] pipe_reg,
  output logic        pass_pulse,
  output logic        pipe_active
);

  typedef struct packed {
    logic [3:0] rsvd;
    logic [9:0] left;
    logic [8:0] centre;
    logic [8:0] height;
  } pipe_t;

  typedef enum logic [1:0] {IDLE, DELAY, SCROLL} state_t;

  // A spawn delay of 0 behaves like 1, so the counter never underflows.
  localparam logic [15:0] DELAY_LD = (SPAWN_DELAY == 0) ? 16'd1 : 16'(SPAWN_DELAY);
  localparam logic [15:0] TAPS     = 16'hB400;  // x^16 + x^14 + x^13 + x^11

  state_t      state, state_nxt;
  pipe_t       pipe_q, pipe_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] lfsr_q;
  logic        pass_nxt;
  logic [9:0]  speed;
  logic [9:0]  left_new;
  logic [10:0] right_old, right_new;
  logic        upd;

  assign upd       = frame_tick & run;
  assign left_new  = pipe_q.left - speed;
  assign right_old = {1'b0, pipe_q.left} + 11'(PIPE_WIDTH);
  assign right_new = {1'b0, left_new} + 11'(PIPE_WIDTH);
  assign pipe_reg  = pipe_q;

  // Free-running Galois LFSR. It ignores run and state, so the gap
  // position depends on when the player starts the game.
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= SEED;
    else         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0);
  end

`ifdef PIPE_SPEEDUP_EN
  localparam logic [9:0] SPEED_MAX = 10'(2 * SPEED);
  logic [2:0] pass_cnt;

  // Speed ramp: add 1 after every 8th pass, saturating at 2*SPEED.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      speed    <= 10'(SPEED);
      pass_cnt <= '0;
    end else if (pass_nxt) begin
      pass_cnt <= pass_cnt + 3'd1;
      if (pass_cnt == 3'd7 && speed < SPEED_MAX) speed <= speed + 10'd1;
    end
  end
`else
  assign speed = 10'(SPEED);
`endif

  // Next-state logic. start wins over frame updates; run low freezes
  // everything except the LFSR.
  always_comb begin
    state_nxt = state;
    pipe_nxt  = pipe_q;
    cnt_nxt   = cnt_q;
    pass_nxt  = 1'b0;
    if (start) begin
      state_nxt = DELAY;
      pipe_nxt  = '0;
      cnt_nxt   = DELAY_LD;
    end else if (upd) begin
      case (state)
        DELAY: begin
          cnt_nxt = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_nxt       = SCROLL;
            pipe_nxt.rsvd   = '0;
            pipe_nxt.left   = 10'(SCREEN_WIDTH);
            pipe_nxt.centre = 9'(GAP_MIN_CENTER) + 9'(lfsr_q[7:0]);
            pipe_nxt.height = 9'(GAP_HEIGHT);
          end
        end
        SCROLL: begin
          if (pipe_q.left < speed) begin
            // The pipe is off-screen: clear it and restart the delay. No pass is signalled here.
            state_nxt = DELAY;
            pipe_nxt  = '0;
            cnt_nxt   = DELAY_LD;
          end else begin
            pipe_nxt.left = left_new;
            pass_nxt      = (right_old >= 11'(BIRD_X)) && (right_new < 11'(BIRD_X));
          end
        end
        default: ;
      endcase
    end
  end

  // Registered state and outputs. Outputs change one clk after the qualifying edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      pipe_q      <= '0;
      cnt_q       <= '0;
      pass_pulse  <= 1'b0;
      pipe_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      pipe_q      <= pipe_nxt;
      cnt_q       <= cnt_nxt;
      pass_pulse  <= pass_nxt;
      pipe_active <= (state_nxt == SCROLL);
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller. A behavioural model of pipe life-cycle phases,
// kept in plain integers, predicts every output every cycle. Directed
// phases come first, then randomized tick/run/start traffic.
module tb_pipe_scroller;
  localparam int          SW   = 640;
  localparam int          PW   = 70;
  localparam int          GH   = 120;
  localparam int          GMC  = 100;
  localparam int          SPD  = 2;
  localparam int          SD   = 40;
  localparam int          BX   = 200;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0, frame_tick = 1'b0, run = 1'b0, start = 1'b0;
  logic [31:0] pipe_reg;
  logic        pass_pulse, pipe_active;

  pipe_scroller #(
    .SCREEN_WIDTH(SW), .PIPE_WIDTH(PW), .GAP_HEIGHT(GH), .GAP_MIN_CENTER(GMC),
    .SPEED(SPD), .SPAWN_DELAY(SD), .BIRD_X(BX), .SEED(SEED)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .run(run), .start(start),
    .pipe_reg(pipe_reg), .pass_pulse(pass_pulse), .pipe_active(pipe_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, pulses = 0;

  // model: phase 0 = no game, 1 = waiting to spawn, 2 = pipe on screen
  int          m_phase = 0, m_wait = 0, m_left = 0, m_centre = 0;
  int          m_speed = SPD, m_passes = 0;
  logic [15:0] m_lfsr = SEED;
  logic [31:0] m_pipe = '0;
  logic        m_pass = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] cur;
    int nl;
    cur    = m_lfsr;
    m_lfsr = {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0);
    m_pass = 1'b0;
    if (!resetn) begin
      m_phase = 0; m_wait = 0; m_lfsr = SEED; m_speed = SPD; m_passes = 0;
    end else if (start) begin
      m_phase = 1; m_wait = (SD == 0) ? 1 : SD; m_speed = SPD; m_passes = 0;
    end else if (frame_tick && run) begin
      if (m_phase == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          m_phase  = 2;
          m_left   = SW;
          m_centre = GMC + int'(cur[7:0]);
        end
      end else if (m_phase == 2) begin
        if (m_left < m_speed) begin
          m_phase = 1;
          m_wait  = (SD == 0) ? 1 : SD;
        end else begin
          nl = m_left - m_speed;
          if (m_left + PW >= BX && nl + PW < BX) m_pass = 1'b1;
          m_left = nl;
`ifdef PIPE_SPEEDUP_EN
          if (m_pass) begin
            m_passes++;
            if (m_passes % 8 == 0 && m_speed < 2 * SPD) m_speed++;
          end
`endif
        end
      end
    end
    m_pipe = (m_phase == 2) ? {4'b0, 10'(m_left), 9'(m_centre), 9'(GH)} : 32'h0;
  endtask

  task automatic cyc(input logic t, input logic r, input logic s);
    frame_tick = t; run = r; start = s;
    @(posedge clk);
    model_step();
    #1;
    chk("pipe_reg", pipe_reg, m_pipe);
    chk("pass_pulse", 32'(pass_pulse), 32'(m_pass));
    chk("pipe_active", 32'(pipe_active), 32'(m_phase == 2));
    if (pass_pulse) pulses++;
  endtask

  task automatic frame(input logic r);
    cyc(1'b1, r, 1'b0);
    repeat (3) cyc(1'b0, r, 1'b0);
  endtask

  initial begin
    int c;
    // reset with run high and ticks present
    resetn = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    resetn = 1'b1;
    // idle without start: nothing ever appears
    repeat (100) frame(1'b1);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // start, then 40 frames -> spawn
    cyc(1'b0, 1'b1, 1'b1);
    repeat (40) frame(1'b1);
    chk("spawn_left", 32'(pipe_reg[27:18]), 32'd640);
    chk("spawn_height", 32'(pipe_reg[8:0]), 32'd120);
    chk("spawn_top", 32'(pipe_reg[31:28]), 32'd0);
    c = int'(pipe_reg[17:9]);
    chk("spawn_centre_rng", 32'(c >= 100 && c <= 355), 32'd1);
    chk("spawn_active", 32'(pipe_active), 32'd1);

    // scroll to left=400, freeze 50 frames, resume
    repeat (120) frame(1'b1);
    chk("left_400", 32'(pipe_reg[27:18]), 32'd400);
    repeat (50) frame(1'b0);
    chk("frozen_left", 32'(pipe_reg[27:18]), 32'd400);
    frame(1'b1);
    chk("resume_left", 32'(pipe_reg[27:18]), 32'd398);
    // ride through the pass and to despawn (frame 321 overall)
    repeat (199) frame(1'b1);
    chk("left_0", 32'(pipe_reg[27:18]), 32'd0);
    chk("pass_once", 32'(pulses), 32'd1);
    frame(1'b1);
    chk("despawn_reg", pipe_reg, 32'h0);
    chk("despawn_active", 32'(pipe_active), 32'd0);
    repeat (40) frame(1'b1);
    chk("respawn_left", 32'(pipe_reg[27:18]), 32'd640);

    // start mid-scroll clears the pipe on the next cycle, even with run low
    repeat (10) frame(1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_reg", pipe_reg, 32'h0);
    chk("restart_active", 32'(pipe_active), 32'd0);

    // randomized traffic, long enough for many pipe lifetimes
    for (int i = 0; i < 24000; i++) begin
      cyc(($urandom_range(0, 1) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 19999) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
